fft_frame_seq: RTL and testbench
================================

FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

Interface
REQ-001 SHALL have parameter N_LOG2, default 9, meaning log2 of frame length N (512 points).
REQ-002 SHALL have parameter DW, default 32, meaning sample width (packed 16-bit re/im).
REQ-003 SHALL have parameter BITREV, default 1, meaning unload read addresses are bit-reversed when 1, natural order when 0.
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_enable  input  1  permits a new frame to start.
REQ-007 SHALL have port i_data  input  DW+1  bit DW = early-last flag, bits DW-1:0 = sample.
REQ-008 SHALL have ports i_data_valid input 1 and o_data_ready output 1, the input-stream handshake.
REQ-009 SHALL have ports o_wr_en output 1, o_wr_addr output N_LOG2 and o_wr_data output DW, the frame-RAM write port.
REQ-010 SHALL have ports o_fft_start output 1 and i_fft_done input 1, the FFT-core start pulse and done pulse.
REQ-011 SHALL have ports o_rd_en output 1, o_rd_addr output N_LOG2 and i_rd_data input DW, the frame-RAM read port with fixed 1-cycle latency.
REQ-012 SHALL have ports o_data output DW, o_data_valid output 1, o_data_last output 1 and i_data_ready input 1, the output stream.
REQ-013 SHALL have ports o_index output N_LOG2 (current load/unload counter) and o_state output 3 (state encoding).

Function
REQ-014 SHALL implement states IDLE=0, LOAD=1, PAD=2, COMPUTE=3, WAIT=4 and UNLOAD=5, shown on o_state.
REQ-015 SHALL move from IDLE to LOAD on the cycle after i_enable=1 and clear o_index to 0.
REQ-016 SHALL drive o_data_ready=1 only in LOAD.
REQ-017 SHALL, in LOAD, assert o_wr_en combinationally on i_data_valid&o_data_ready, with o_wr_addr=o_index and o_wr_data=i_data[DW-1:0], and increment o_index per accepted sample.
REQ-018 SHALL, when the accepted sample has o_index=N-1, go to COMPUTE regardless of the flag bit.
REQ-019 SHALL, when the accepted sample has flag=1 and o_index<N-1, go to PAD.
REQ-020 SHALL, in PAD, write zero to one address per cycle from o_index+1 to N-1, then go to COMPUTE.
REQ-021 SHALL pulse o_fft_start high for exactly one cycle, the single COMPUTE cycle, then go to WAIT.
REQ-022 SHALL, in WAIT, go to UNLOAD on i_fft_done=1 and clear o_index.
REQ-023 SHALL ignore i_fft_done in every state other than WAIT.
REQ-024 SHALL, in UNLOAD, issue o_rd_en with o_rd_addr = bit-reverse(o_index) when BITREV=1, else o_index.
REQ-025 SHALL buffer read data in a 2-entry output buffer and issue a read only when buffered + in-flight entries < 2, so no data is lost under back-pressure.
REQ-026 SHALL hold o_data, o_data_valid and o_data_last stable while o_data_valid=1 and i_data_ready=0.
REQ-027 SHALL assert o_data_last with the N-th output word only.
REQ-028 SHALL, on the handshake of the last word, go to LOAD if i_enable=1 (o_index cleared), else to IDLE.
REQ-029 SHALL keep the counter N_LOG2 bits wide with no wrap-around: it stops at N-1 on a terminal event.

Reset
REQ-030 SHALL, when i_rst=1 at a rising edge (in any state, including mid-frame), enter IDLE with o_index=0, the output buffer emptied, and o_data_ready, o_wr_en, o_rd_en, o_fft_start, o_data_valid, o_data_last, o_data, o_wr_addr, o_rd_addr and o_wr_data all 0.
REQ-031 SHALL not emit o_fft_start or stream-side activity in the cycle following reset release.

Verification
REQ-032 SHALL pass this test: i_enable=1, 512 samples 0..511 with valid held high -> writes addr k=data k, one o_fft_start pulse after write 511; i_fft_done 5 cycles later -> 512 outputs, with output j = RAM[bitrev9(j)] (j=1 gives addr 256) and last on output 511.
REQ-033 SHALL pass this test: flag=1 on sample index 99 -> PAD writes zeros to addresses 100..511 (412 cycles), then a single o_fft_start.
REQ-034 SHALL pass this test: i_data_ready toggled randomly 50% in UNLOAD -> exactly 512 outputs, none dropped or duplicated, stable while stalled.
REQ-035 SHALL pass this test: i_fft_done pulsed during LOAD and UNLOAD -> no state change; only the WAIT-state pulse advances.
REQ-036 SHALL pass this test: i_rst asserted at load index 300 -> next cycle o_state=0, o_index=0, all outputs 0; the next frame loads from address 0.
REQ-037 SHALL pass this test: BITREV=0 with i_enable held high -> natural-order readout, and LOAD re-entered the cycle after the last output handshake.

Source files
------------

// File: rtl/fft_frame_seq.sv
// Frame sequencer around an in-place FFT core: loads one frame into RAM
// (zero-padding short frames), starts the core, waits for done, then
// streams the frame back out (optionally bit-reversed) with back-pressure.
module fft_frame_seq #(
    parameter int N_LOG2 = 9,
    parameter int DW     = 32,
    parameter int BITREV = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [DW:0]       i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic              o_wr_en,
    output logic [N_LOG2-1:0] o_wr_addr,
    output logic [DW-1:0]     o_wr_data,
    output logic              o_fft_start,
    input  logic              i_fft_done,
    output logic              o_rd_en,
    output logic [N_LOG2-1:0] o_rd_addr,
    input  logic [DW-1:0]     i_rd_data,
    output logic [DW-1:0]     o_data,
    output logic              o_data_valid,
    output logic              o_data_last,
    input  logic              i_data_ready,
    output logic [N_LOG2-1:0] o_index,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PAD     = 3'd2,
        S_COMPUTE = 3'd3,
        S_WAIT    = 3'd4,
        S_UNLOAD  = 3'd5
    } state_t;

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    state_t            state;
    logic [N_LOG2-1:0] index;
    logic              rd_all;      // every read address of the frame has been issued

    // Read pipeline: request in flight (RAM latency 1) and its last-word tag
    logic              rd_vld_p1;
    logic              rd_last_p1;

    // Two-entry output buffer
    logic [DW-1:0]     buf_data [2];
    logic              buf_last [2];
    logic              wptr;
    logic              rptr;
    logic [1:0]        cnt;

    logic              accept;
    logic              pop;
    logic [2:0]        credit;
    logic              rd_issue;

    function automatic logic [N_LOG2-1:0] bit_reverse(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = a[N_LOG2-1-i];
        end
        return r;
    endfunction

    // Handshakes, RAM ports and read-issue credit derived from registered state
    always_comb begin
        accept       = (state == S_LOAD) && i_data_valid;
        o_data_valid = (cnt != 2'd0);
        pop          = o_data_valid && i_data_ready;
        // A word leaving this cycle frees its slot for a read issued now
        credit       = {1'b0, cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
        rd_issue     = (state == S_UNLOAD) && !rd_all && (credit < 3'd2);

        o_data_ready = (state == S_LOAD);
        o_wr_en      = accept || (state == S_PAD);
        o_wr_addr    = index;
        o_wr_data    = accept ? i_data[DW-1:0] : '0;
        o_fft_start  = (state == S_COMPUTE);
        o_rd_en      = rd_issue;
        o_rd_addr    = '0;
        if (state == S_UNLOAD) begin
            o_rd_addr = (BITREV != 0) ? bit_reverse(index) : index;
        end
        o_data       = o_data_valid ? buf_data[rptr] : '0;
        o_data_last  = o_data_valid && buf_last[rptr];
        o_index      = index;
        o_state      = state;
    end

    // Frame sequencing FSM and shared load/unload counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            index  <= '0;
            rd_all <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state <= S_LOAD;
                        index <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (index == LAST_IDX) begin
                            state <= S_COMPUTE;
                        end else begin
                            index <= index + 1'b1;
                            if (i_data[DW]) state <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (index == LAST_IDX) state <= S_COMPUTE;
                    else                   index <= index + 1'b1;
                end
                S_COMPUTE: state <= S_WAIT;
                S_WAIT: begin
                    if (i_fft_done) begin
                        state  <= S_UNLOAD;
                        index  <= '0;
                        rd_all <= 1'b0;
                    end
                end
                S_UNLOAD: begin
                    if (rd_issue) begin
                        if (index == LAST_IDX) rd_all <= 1'b1;
                        else                   index  <= index + 1'b1;
                    end
                    if (pop && o_data_last) begin
                        if (i_enable) begin
                            state <= S_LOAD;
                            index <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-in-flight tracking and output buffer occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            cnt        <= 2'd0;
        end else begin
            rd_vld_p1  <= rd_issue;
            rd_last_p1 <= rd_issue && (index == LAST_IDX);
            if (rd_vld_p1) wptr <= ~wptr;
            if (pop)       rptr <= ~rptr;
            cnt <= cnt + {1'b0, rd_vld_p1} - {1'b0, pop};
        end
    end

    // Output buffer storage: capture returning RAM data one cycle after the read
    always_ff @(posedge i_clk) begin
        if (rd_vld_p1) begin
            buf_data[wptr] <= i_rd_data;
            buf_last[wptr] <= rd_last_p1;
        end
    end

endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq: a 512-point bit-reversed instance and an
// 8-point natural-order instance, each with a behavioural frame RAM.
module tb_fft_frame_seq;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int errors  = 0;

    // 512-point, bit-reversed instance
    logic        rst, en, dval, dready, wr_en, fft_start, fft_done, rd_en;
    logic [32:0] din;
    logic [8:0]  wr_addr, rd_addr, idx;
    logic [31:0] wr_data, rd_data, dout;
    logic        dout_v, dout_l, out_rdy;
    logic [2:0]  st;

    // 8-point, natural-order instance
    logic        n_en, n_dval, n_dready, n_wr_en, n_start, n_done, n_rd_en;
    logic [32:0] n_din;
    logic [2:0]  n_wr_addr, n_rd_addr, n_idx;
    logic [31:0] n_wr_data, n_rd_data, n_dout;
    logic        n_dout_v, n_dout_l, n_out_rdy;
    logic [2:0]  n_st;

    logic [31:0] ram     [512];
    logic [31:0] n_ram   [8];
    logic [31:0] exp_mem [512];
    int          starts   = 0;

    fft_frame_seq #(.N_LOG2(9), .DW(32), .BITREV(1)) u_dut (
        .i_clk(i_clk), .i_rst(rst), .i_enable(en), .i_data(din),
        .i_data_valid(dval), .o_data_ready(dready),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_fft_start(fft_start), .i_fft_done(fft_done),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_data(dout), .o_data_valid(dout_v), .o_data_last(dout_l),
        .i_data_ready(out_rdy), .o_index(idx), .o_state(st)
    );

    fft_frame_seq #(.N_LOG2(3), .DW(32), .BITREV(0)) u_nat (
        .i_clk(i_clk), .i_rst(rst), .i_enable(n_en), .i_data(n_din),
        .i_data_valid(n_dval), .o_data_ready(n_dready),
        .o_wr_en(n_wr_en), .o_wr_addr(n_wr_addr), .o_wr_data(n_wr_data),
        .o_fft_start(n_start), .i_fft_done(n_done),
        .o_rd_en(n_rd_en), .o_rd_addr(n_rd_addr), .i_rd_data(n_rd_data),
        .o_data(n_dout), .o_data_valid(n_dout_v), .o_data_last(n_dout_l),
        .i_data_ready(n_out_rdy), .o_index(n_idx), .o_state(n_st)
    );

    always @(posedge i_clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        if (rd_en) rd_data <= ram[rd_addr];
        if (n_wr_en) n_ram[n_wr_addr] <= n_wr_data;
        if (n_rd_en) n_rd_data <= n_ram[n_rd_addr];
        if (fft_start) starts = starts + 1;
    end

    function automatic logic [8:0] rev9(input logic [8:0] a);
        logic [8:0] r = '0;
        logic [8:0] v = a;
        repeat (9) begin
            r = {r[7:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; dval = 1'b1; din = 33'h1_2345_6789;
        fft_done = 1'b1; out_rdy = 1'b1;
        n_en = 1'b0; n_dval = 1'b0; n_din = '0; n_done = 1'b0; n_out_rdy = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        vectors++;
        if ({st, idx} !== 12'd0) begin
            errors++; $display("FAIL reset_state got st=%0d idx=%0d want 0/0", st, idx);
        end
        vectors++;
        if ({dready, wr_en, rd_en, fft_start, dout_v, dout_l, dout, wr_addr, rd_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b wr=%b rd=%b st=%b v=%b l=%b d=%h wa=%h ra=%h wd=%h want all 0",
                     dready, wr_en, rd_en, fft_start, dout_v, dout_l, dout, wr_addr, rd_addr, wr_data);
        end
        @(negedge i_clk);
        rst = 1'b0; dval = 1'b0; fft_done = 1'b0;
        @(negedge i_clk); #1;
        vectors++;
        if ({st, fft_start, dout_v, dready} !== 6'd0 || starts != 0) begin
            errors++; $display("FAIL post_reset got st=%0d start=%b v=%b rdy=%b starts=%0d want idle/quiet",
                               st, fft_start, dout_v, dready, starts);
        end
    endtask

    // Drain one 512-word frame; rnd randomises ready, pulse toggles fft_done
    task automatic collect(input bit rnd, input bit pulse);
        int          j = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        while (j < 512 && cyc < 5000) begin
            @(negedge i_clk);
            cyc++;
            out_rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            fft_done = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (stalled) begin
                vectors++;
                if ({dout_v, dout_l, dout} !== {1'b1, pl, pd}) begin
                    errors++; $display("FAIL stall_hold j=%0d got v=%b l=%b d=%h want v=1 l=%b d=%h",
                                       j, dout_v, dout_l, dout, pl, pd);
                end
            end
            vectors++;
            if (st !== 3'd5) begin
                errors++; $display("FAIL unload_state j=%0d got %0d want 5", j, st);
            end
            if (dout_v && out_rdy) begin
                vectors++;
                if ({dout, dout_l} !== {exp_mem[rev9(9'(j))], (j == 511)}) begin
                    errors++; $display("FAIL out_word j=%0d got %h last=%b want %h last=%b",
                                       j, dout, dout_l, exp_mem[rev9(9'(j))], (j == 511));
                end
                j++;
            end
            stalled = dout_v && !out_rdy;
            pd = dout;
            pl = dout_l;
        end
        vectors++;
        if (j != 512) begin
            errors++; $display("FAIL unload_timeout got %0d words want 512", j);
        end
        out_rdy = 1'b1; fft_done = 1'b0;
        @(negedge i_clk); #1;
        vectors++;
        if ({st, dout_v} !== 4'd0) begin
            errors++; $display("FAIL unload_end got st=%0d v=%b want 0/0", st, dout_v);
        end
    endtask

    // Wait in WAIT for five cycles, then pulse done and check UNLOAD entry
    task automatic wait_and_done;
        repeat (4) begin
            @(negedge i_clk); #1;
            vectors++;
            if (st !== 3'd4) begin
                errors++; $display("FAIL wait_hold got %0d want 4", st);
            end
        end
        @(negedge i_clk); fft_done = 1'b1;
        @(negedge i_clk); fft_done = 1'b0; #1;
        vectors++;
        if ({st, idx} !== {3'd5, 9'd0}) begin
            errors++; $display("FAIL unload_entry got st=%0d idx=%0d want 5/0", st, idx);
        end
    endtask

    task automatic test_full_frame;
        int s0 = starts;
        @(negedge i_clk); en = 1'b1;
        @(negedge i_clk); en = 1'b0; #1;
        vectors++;
        if ({st, idx, dready} !== {3'd1, 9'd0, 1'b1}) begin
            errors++; $display("FAIL load_entry got st=%0d idx=%0d rdy=%b want 1/0/1", st, idx, dready);
        end
        for (int k = 0; k < 512; k++) begin
            if (k > 0) @(negedge i_clk);
            dval = 1'b1; din = {1'b0, 32'(k)}; exp_mem[k] = 32'(k);
            #1;
            vectors++;
            if ({wr_en, wr_addr, wr_data, fft_start} !== {1'b1, 9'(k), 32'(k), 1'b0}) begin
                errors++; $display("FAIL load_write k=%0d got en=%b a=%0d d=%0d st=%b want 1/%0d/%0d/0",
                                   k, wr_en, wr_addr, wr_data, fft_start, k, k);
            end
        end
        @(negedge i_clk); dval = 1'b0; #1;
        vectors++;
        if ({st, idx, fft_start} !== {3'd3, 9'd511, 1'b1}) begin
            errors++; $display("FAIL compute got st=%0d idx=%0d start=%b want 3/511/1", st, idx, fft_start);
        end
        @(negedge i_clk); #1;
        vectors++;
        if ({st, fft_start} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL wait_entry got st=%0d start=%b want 4/0", st, fft_start);
        end
        wait_and_done();
        vectors++;
        if (starts - s0 != 1) begin
            errors++; $display("FAIL start_count got %0d want 1", starts - s0);
        end
        collect(1'b0, 1'b0);
    endtask

    task automatic test_pad_backpressure;
        int s0 = starts;
        @(negedge i_clk); en = 1'b1;
        @(negedge i_clk); en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge i_clk);
            dval = 1'b1; din = {(k == 99), 32'(1000 + k)}; exp_mem[k] = 32'(1000 + k);
            fft_done = (k % 7 == 0);
            #1;
            vectors++;
            if ({st, wr_en, wr_addr, wr_data} !== {3'd1, 1'b1, 9'(k), 32'(1000 + k)}) begin
                errors++; $display("FAIL pad_load k=%0d got st=%0d en=%b a=%0d d=%0d want 1/1/%0d/%0d",
                                   k, st, wr_en, wr_addr, wr_data, k, 1000 + k);
            end
        end
        for (int a = 100; a < 512; a++) exp_mem[a] = 32'd0;
        for (int i = 0; i < 412; i++) begin
            @(negedge i_clk); dval = 1'b0; fft_done = 1'b0; #1;
            vectors++;
            if ({st, wr_en, wr_addr, wr_data} !== {3'd2, 1'b1, 9'(100 + i), 32'd0}) begin
                errors++; $display("FAIL pad_write i=%0d got st=%0d en=%b a=%0d d=%0d want 2/1/%0d/0",
                                   i, st, wr_en, wr_addr, wr_data, 100 + i);
            end
        end
        @(negedge i_clk); #1;
        vectors++;
        if ({st, fft_start} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL pad_compute got st=%0d start=%b want 3/1", st, fft_start);
        end
        @(negedge i_clk);
        wait_and_done();
        vectors++;
        if (starts - s0 != 1) begin
            errors++; $display("FAIL pad_start_count got %0d want 1", starts - s0);
        end
        collect(1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        int j;
        int cyc;
        @(negedge i_clk); n_en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge i_clk);
                n_dval = 1'b1; n_din = {1'b0, 32'(10 * (f + 1) + k)};
                #1;
                vectors++;
                if ({n_st, n_wr_en, n_wr_addr, n_wr_data} !== {3'd1, 1'b1, 3'(k), 32'(10 * (f + 1) + k)}) begin
                    errors++; $display("FAIL nat_load f=%0d k=%0d got st=%0d en=%b a=%0d d=%0d",
                                       f, k, n_st, n_wr_en, n_wr_addr, n_wr_data);
                end
            end
            @(negedge i_clk); n_dval = 1'b0; #1;
            vectors++;
            if ({n_st, n_start} !== {3'd3, 1'b1}) begin
                errors++; $display("FAIL nat_compute f=%0d got st=%0d start=%b want 3/1", f, n_st, n_start);
            end
            @(negedge i_clk); n_done = 1'b1;
            @(negedge i_clk); n_done = 1'b0;
            j = 0; cyc = 0;
            while (j < 8 && cyc < 100) begin
                if (cyc > 0) @(negedge i_clk);
                cyc++;
                #1;
                if (n_dout_v) begin
                    vectors++;
                    if ({n_dout, n_dout_l} !== {32'(10 * (f + 1) + j), (j == 7)}) begin
                        errors++; $display("FAIL nat_out f=%0d j=%0d got %0d last=%b want %0d last=%b",
                                           f, j, n_dout, n_dout_l, 10 * (f + 1) + j, (j == 7));
                    end
                    j++;
                end
            end
            vectors++;
            if (j != 8) begin
                errors++; $display("FAIL nat_timeout f=%0d got %0d words want 8", f, j);
            end
            @(negedge i_clk); #1;
            vectors++;
            if ({n_st, n_idx, n_dout_v} !== {3'd1, 3'd0, 1'b0}) begin
                errors++; $display("FAIL nat_reload f=%0d got st=%0d idx=%0d v=%b want 1/0/0",
                                   f, n_st, n_idx, n_dout_v);
            end
        end
        n_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge i_clk); en = 1'b1;
        @(negedge i_clk); en = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge i_clk);
            dval = 1'b1; din = {1'b0, 32'(5000 + k)};
        end
        @(negedge i_clk); #1;
        vectors++;
        if ({st, idx} !== {3'd1, 9'd300}) begin
            errors++; $display("FAIL mid_index got st=%0d idx=%0d want 1/300", st, idx);
        end
        rst = 1'b1; din = {1'b0, 32'hDEAD_BEEF};
        @(negedge i_clk); rst = 1'b0; #1;
        vectors++;
        if ({st, idx} !== 12'd0) begin
            errors++; $display("FAIL mid_reset_state got st=%0d idx=%0d want 0/0", st, idx);
        end
        vectors++;
        if ({dready, wr_en, rd_en, fft_start, dout_v, dout_l, dout, wr_addr, rd_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got rdy=%b wr=%b rd=%b st=%b v=%b l=%b d=%h wa=%h ra=%h wd=%h want all 0",
                     dready, wr_en, rd_en, fft_start, dout_v, dout_l, dout, wr_addr, rd_addr, wr_data);
        end
        en = 1'b1;
        @(negedge i_clk); en = 1'b0; din = {1'b0, 32'd7}; #1;
        vectors++;
        if ({st, wr_en, wr_addr, wr_data} !== {3'd1, 1'b1, 9'd0, 32'd7}) begin
            errors++; $display("FAIL mid_reload got st=%0d en=%b a=%0d d=%0d want 1/1/0/7",
                               st, wr_en, wr_addr, wr_data);
        end
        @(negedge i_clk); dval = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_pad_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
